wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two sources:
  - the pipeline writeback stage (primary source);
  - the long-latency multiply/divide unit ("lu"), whose results arrive out of band.
- Buffers lu results in a small FIFO and drains them into idle write-port cycles.
- Forces a one-cycle pipeline stall when a buffered result has waited too long.
- Sits between the writeback stage outputs (data, destination, write enable) and the register file write port inside decode.

Parameters:
- DATA_W, 32: register data width.
- FIFO_DEPTH, 2: lu result buffer entries (power of two, at least 2).
- MAX_WAIT, 4: number of cycles a valid FIFO head may be denied before a forced drain.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_we  in  1  writeback stage requests a register write.
- wb_dst  in  5  writeback destination register.
- wb_data  in  DATA_W  writeback data.
- lu_valid  in  1  lu result valid.
- lu_dst  in  5  lu destination register.
- lu_data  in  DATA_W  lu result.
- lu_ready  out  1  arbiter can accept an lu result this cycle.
- rf_we  out  1  register file write enable.
- rf_dst  out  5  register file write address.
- rf_data  out  DATA_W  register file write data.
- stall_req  out  1  pipeline must hold its writeback stage this cycle.

Behaviour:
- Reset:
  - rf_we=0, rf_dst=0, rf_data=0, stall_req=0.
  - FIFO emptied, age counter=0, state=NORMAL.
  - lu_ready is 1 in the first cycle after reset.
- Synchronous reset mid-operation discards all buffered lu results; the lu unit must reissue them.
- lu_ready = (count < FIFO_DEPTH), based on the current count only.
  - A push and a pop in the same cycle at full is not permitted: lu_ready=0 when full.
- Push: on a clock edge where lu_valid && lu_ready.
  - Entries with lu_dst==0 are pushed and later drained with rf_we suppressed.
- pipe_live = wb_we && (wb_dst != 0).
- State NORMAL:
  - pipe_live: select pipeline. Next rf_we=1, rf_dst=wb_dst, rf_data=wb_data.
  - !pipe_live and FIFO non-empty: pop head. Next rf_we=(head.dst!=0), rf_dst=head.dst, rf_data=head.data.
  - Otherwise next rf_we=0; rf_dst and rf_data hold their previous values.
  - Age counter:
    - increments when the FIFO is non-empty and the head is not popped;
    - clears on a pop or when the FIFO is empty.
  - If the age counter reaches MAX_WAIT-1 and this cycle increments it: next state FORCE and stall_req<=1.
- State FORCE (stall_req=1 for exactly this one cycle):
  - Unconditionally pop the head onto the write port; wb_* inputs are ignored.
  - The pipeline holds its writeback stage and re-presents the same wb_* next cycle.
  - Age counter clears; next state NORMAL; stall_req<=0.
- Latency:
  - Pipeline write: rf_* are registered one cycle after wb_* are sampled.
  - lu result: earliest rf_we is 2 edges after the push edge (push edge, then decide and register).
- Write ordering:
  - A pipeline write and an lu write to the same register are not reordered or merged by this block.
  - The decode/hazard logic guarantees no WAW conflict between them.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Simultaneous push into an empty FIFO while the port is idle: the entry is not bypassed; it is written on the following cycle.
- At most one register file write per cycle, always.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and DATA_W default;
  - the state enum {NORMAL, FORCE};
  - the zero-register constant 5'h0.
- One sub-module is natural: wb_result_fifo, a parameterised synchronous FIFO with push/pop/count/head and synchronous active-high reset.
- Arbitration, the age counter and the FSM stay in wb_port_arbiter.

Test Plan:
- Pipeline only: wb_we=1, wb_dst=5, wb_data=0xDEADBEEF, lu_valid=0 -> next cycle rf_we=1, rf_dst=5, rf_data=0xDEADBEEF; stall_req stays 0.
- Idle drain: lu_valid=1, lu_dst=9, lu_data=0x12345678 for one cycle, wb_we=0 throughout -> rf_we=1, rf_dst=9, rf_data=0x12345678 exactly 2 edges after the push; lu_ready stays 1.
- Full backpressure: two lu pushes while wb_we=1, wb_dst=3 continuously -> count=2, lu_ready=0; a third lu_valid is not accepted; rf_dst=3 every cycle until the forced drain.
- Starvation: one lu entry (dst=7) with wb_we=1, wb_dst=4 every cycle -> after 4 denied cycles stall_req=1 for exactly 1 cycle; the next rf_dst=7; then rf_dst=4 resumes with the held wb_data.
- Zero register: wb_we=1, wb_dst=0 with the FIFO holding dst=0 then dst=2 -> head dst=0 pops with rf_we=0; the dst=2 entry writes on the next cycle.
- Reset mid-operation: FIFO holding 2 entries and state FORCE, assert reset for 1 cycle -> rf_we=0, stall_req=0, lu_ready=1; no stale entry is ever written afterwards.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W_DEF = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'h0;

   // Arbiter states, kept as plain constants for legacy tool flows
   typedef logic [0:0] arb_state_t;
   localparam arb_state_t NORMAL = 1'b0;
   localparam arb_state_t FORCE  = 1'b1;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering long-latency unit results ({dst, data}).
module wb_result_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty,
   output logic             o_full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage needs no reset: a zero count makes stale entries unreachable
   always_ff @(posedge i_clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between writeback and buffered lu results,
// forcing a one-cycle stall when the oldest lu result has been starved too long.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_wb_we,
   input  logic [REG_ADDR_W-1:0] i_wb_dst,
   input  logic [DATA_W-1:0]     i_wb_data,
   input  logic                  i_lu_valid,
   input  logic [REG_ADDR_W-1:0] i_lu_dst,
   input  logic [DATA_W-1:0]     i_lu_data,
   output logic                  o_lu_ready,
   output logic                  o_rf_we,
   output logic [REG_ADDR_W-1:0] o_rf_dst,
   output logic [DATA_W-1:0]     o_rf_data,
   output logic                  o_stall_req
);

   localparam int unsigned ENTRY_W = REG_ADDR_W + DATA_W;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned AGE_W   = $clog2(MAX_WAIT + 1);

   logic                  r_rf_we;
   logic [REG_ADDR_W-1:0] r_rf_dst;
   logic [DATA_W-1:0]     r_rf_data;
   logic                  r_stall;
   arb_state_t            r_state;
   logic [AGE_W-1:0]      r_age;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_sel_pipe;
   logic                  w_pipe_live;
   logic                  w_age_inc;
   logic                  w_empty;
   logic                  w_full;
   logic [CNT_W-1:0]      w_count;
   logic [ENTRY_W-1:0]    w_head;
   logic [REG_ADDR_W-1:0] w_head_dst;
   logic [DATA_W-1:0]     w_head_data;

   assign o_lu_ready  = !w_full;
   assign w_push      = i_lu_valid && !w_full;
   assign w_pipe_live = i_wb_we && (i_wb_dst != ZERO_REG);
   assign {w_head_dst, w_head_data} = w_head;

   wb_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_wdata ({i_lu_dst, i_lu_data}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // Port selection: FORCE drains the head; otherwise pipeline wins, lu fills idle slots
   always_comb begin
      w_pop      = 1'b0;
      w_sel_pipe = 1'b0;
      if (r_state == FORCE) begin
         w_pop = !w_empty;
      end else if (w_pipe_live) begin
         w_sel_pipe = 1'b1;
      end else if (!w_empty) begin
         w_pop = 1'b1;
      end
      w_age_inc = (r_state == NORMAL) && !w_empty && !w_pop;
   end

   // Registered write port, age counter and starvation FSM
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rf_we   <= 1'b0;
         r_rf_dst  <= '0;
         r_rf_data <= '0;
         r_stall   <= 1'b0;
         r_state   <= NORMAL;
         r_age     <= '0;
      end else begin
         if (w_sel_pipe) begin
            r_rf_we   <= 1'b1;
            r_rf_dst  <= i_wb_dst;
            r_rf_data <= i_wb_data;
         end else if (w_pop) begin
            // Zero-register entries still drain, just without a write
            r_rf_we   <= (w_head_dst != ZERO_REG);
            r_rf_dst  <= w_head_dst;
            r_rf_data <= w_head_data;
         end else begin
            r_rf_we <= 1'b0;
         end

         r_age <= w_age_inc ? r_age + 1'b1 : '0;

         if (r_state == FORCE) begin
            r_state <= NORMAL;
            r_stall <= 1'b0;
         end else if (w_age_inc && (r_age == AGE_W'(MAX_WAIT - 1))) begin
            r_state <= FORCE;
            r_stall <= 1'b1;
         end
      end
   end

   assign o_rf_we     = r_rf_we;
   assign o_rf_dst    = r_rf_dst;
   assign o_rf_data   = r_rf_data;
   assign o_stall_req = r_stall;

   logic w_unused;
   assign w_unused = ^w_count;

endmodule
